uart_vram_writer: RTL
=====================

Name: uart_vram_writer

Overview:
- Sequencer between the UART receiver and the video core's VRAM write port.
- Pairs received bytes into 16-bit words (high byte first) and issues single-cycle VRAM writes at an auto-incrementing, wrapping address.
- Resynchronises byte pairing after an inter-byte timeout.
- Owns the write port during a hardware screen clear and holds one word that completes during the clear, so pairing is never lost.

Parameters:
- ADDR_W, 10, VRAM address width; depth is 2**ADDR_W words.
- TIMEOUT, 50000, idle CLK cycles after a high byte before that high byte is discarded.
- FILL, 16'h0000, word written to every location by a clear.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- RX_DATA  in  8  received byte.
- RX_VALID  in  1  one-cycle strobe; RX_DATA valid this cycle.
- CLEAR_REQ  in  1  one-cycle request to fill VRAM with FILL.
- SET_ADDR  in  1  one-cycle strobe to load the write pointer from ADDR_IN.
- ADDR_IN  in  ADDR_W  new write pointer value.
- VRAM_WREN  out  1  one-cycle write strobe.
- VRAM_WRADDR  out  ADDR_W  write address.
- VRAM_DATA  out  16  write data.
- BUSY  out  1  high while a clear is in progress.
- RESYNC  out  1  one-cycle pulse when a timeout discards a high byte.
- OVERFLOW  out  1  sticky; set when a completed word is dropped.
- LAST_WORD  out  16  last UART-sourced word written (FILL writes excluded), for the seven-segment display.

Behaviour:
- Reset values:
  - All outputs 0; BUSY=0.
  - Write pointer wr_ptr=0.
  - Byte phase=HI.
  - Pending-word register empty.
  - Timeout counter 0.
  - Main FSM in IDLE.
- All outputs are registered. VRAM_WREN is high for exactly one cycle per write, with VRAM_WRADDR and VRAM_DATA valid in the same cycle.
- Byte phase (runs in both IDLE and CLEAR):
  - HI + RX_VALID: latch hi=RX_DATA; phase goes to LO; counter cleared.
  - LO + RX_VALID: word={hi,RX_DATA} completes; phase goes to HI.
  - LO without RX_VALID: counter increments. At TIMEOUT-1: phase goes to HI, hi is discarded, and RESYNC pulses the following cycle.
- Word completion in IDLE:
  - If pending is empty, at the same edge: VRAM_WREN<=1, VRAM_WRADDR<=wr_ptr, VRAM_DATA<=word, LAST_WORD<=word, wr_ptr<=wr_ptr+1.
  - Latency: WREN is high the cycle after the low-byte RX_VALID.
- Word completion in CLEAR:
  - If pending is empty: store the word in pending.
  - If pending is full: drop the word and set OVERFLOW (cleared only by RST).
- FSM IDLE:
  - CLEAR_REQ: go to CLEAR, BUSY<=1, clr_addr=0.
  - SET_ADDR: wr_ptr<=ADDR_IN.
  - Pending full on entry to IDLE: write pending at wr_ptr on the first IDLE edge, increment wr_ptr, clear pending.
  - A word completing on that same edge goes to pending and is written on the next edge.
- FSM CLEAR:
  - Each cycle: WREN=1, addr=clr_addr, data=FILL; clr_addr increments.
  - After addr 2**ADDR_W-1 is written: wr_ptr<=0, BUSY<=0, go to IDLE.
  - Exactly 2**ADDR_W consecutive WREN cycles.
  - CLEAR_REQ and SET_ADDR are ignored in CLEAR.
- Simultaneous events in IDLE:
  - Word completion + SET_ADDR: the write uses the old wr_ptr, then wr_ptr<=ADDR_IN (SET_ADDR overrides the increment).
  - Word completion + CLEAR_REQ: the clear wins. The word goes to pending and is written at addr 0 after the clear.
  - CLEAR_REQ + SET_ADDR: the clear wins; SET_ADDR is ignored.
- Wrap: wr_ptr increments modulo 2**ADDR_W (max goes to 0), with no flag.
- RST mid-clear or mid-word: abort immediately. Discard pending and hi; all state returns to reset values; no further WREN.

Test Plan:
- Reset, then bytes 0x12,0x34,0x56,0x78 -> WREN at addr 0 data 0x1234, then addr 1 data 0x5678; each WREN one cycle after the low byte; LAST_WORD=0x5678.
- SET_ADDR with ADDR_IN=0x3FF, then 4 bytes AA BB CC DD -> writes 0xAABB@0x3FF, then 0xCCDD@0x000 (wrap).
- Byte 0x12, idle TIMEOUT cycles, then 0xAB,0xCD -> RESYNC pulses once; no write of 0x12xx; write 0xABCD@0.
- CLEAR_REQ with FILL=0 -> BUSY high; 1024 consecutive WREN at addr 0..1023 data 0; then BUSY low and wr_ptr=0.
- During a clear, bytes 11 22 33 44 -> 0x1122 held and written @0 on the first IDLE edge; 0x3344 dropped; OVERFLOW=1.
- RST asserted at clr_addr=500 -> next cycle all outputs 0, BUSY=0, no WREN; bytes 01 02 then write 0x0102@0.

Source files
------------

// File: rtl/uart_vram_writer.sv
// Pairs UART bytes into 16-bit words and writes them to VRAM at an auto-incrementing address.
// A hardware clear owns the write port; one word completing during the clear is held and written afterwards.
module uart_vram_writer #(
  parameter int          ADDR_W  = 10,
  parameter int          TIMEOUT = 50000,
  parameter logic [15:0] FILL    = 16'h0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  input  logic              CLEAR_REQ,
  input  logic              SET_ADDR,
  input  logic [ADDR_W-1:0] ADDR_IN,
  output logic              VRAM_WREN,
  output logic [ADDR_W-1:0] VRAM_WRADDR,
  output logic [15:0]       VRAM_DATA,
  output logic              BUSY,
  output logic              RESYNC,
  output logic              OVERFLOW,
  output logic [15:0]       LAST_WORD
);
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nxt;

  logic              phase_lo;
  logic [7:0]        hi;
  logic [CNT_W-1:0]  tcnt;
  logic              pend_vld;
  logic [15:0]       pend_data;
  logic [ADDR_W-1:0] wr_ptr, clr_addr;

  logic        word_done, start_clear, clear_done, idle_wr, word_to_pend, word_drop;
  logic [15:0] word, idle_data;

  assign word_done = phase_lo && RX_VALID;
  assign word      = {hi, RX_DATA};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_clear  = 1'b0;
    clear_done   = 1'b0;
    idle_wr      = 1'b0;
    idle_data    = word;
    word_to_pend = 1'b0;
    word_drop    = 1'b0;
    case (state)
      IDLE: begin
        if (CLEAR_REQ) begin
          start_clear  = 1'b1;
          state_nxt    = CLEAR;
          word_to_pend = word_done && !pend_vld;
          word_drop    = word_done && pend_vld;
        end else if (pend_vld) begin
          // pending drains this edge, so a word completing now takes its slot
          idle_wr      = 1'b1;
          idle_data    = pend_data;
          word_to_pend = word_done;
        end else begin
          idle_wr = word_done;
        end
      end
      CLEAR: begin
        word_to_pend = word_done && !pend_vld;
        word_drop    = word_done && pend_vld;
        if (clr_addr == ADDR_MAX) begin
          clear_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_lo    <= 1'b0;
      hi          <= '0;
      tcnt        <= '0;
      pend_vld    <= 1'b0;
      pend_data   <= '0;
      wr_ptr      <= '0;
      clr_addr    <= '0;
      VRAM_WREN   <= 1'b0;
      VRAM_WRADDR <= '0;
      VRAM_DATA   <= '0;
      BUSY        <= 1'b0;
      RESYNC      <= 1'b0;
      OVERFLOW    <= 1'b0;
      LAST_WORD   <= '0;
    end else begin
      VRAM_WREN <= 1'b0;
      RESYNC    <= 1'b0;

      if (RX_VALID) begin
        if (!phase_lo) begin
          hi       <= RX_DATA;
          phase_lo <= 1'b1;
          tcnt     <= '0;
        end else begin
          phase_lo <= 1'b0;
        end
      end else if (phase_lo) begin
        if (tcnt == CNT_LAST) begin
          phase_lo <= 1'b0;
          RESYNC   <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end

      if (state == CLEAR) begin
        VRAM_WREN   <= 1'b1;
        VRAM_WRADDR <= clr_addr;
        VRAM_DATA   <= FILL;
        clr_addr    <= clr_addr + 1'b1;
        if (clear_done) begin
          wr_ptr <= '0;
          BUSY   <= 1'b0;
        end
      end else if (start_clear) begin
        BUSY     <= 1'b1;
        clr_addr <= '0;
      end else begin
        if (idle_wr) begin
          VRAM_WREN   <= 1'b1;
          VRAM_WRADDR <= wr_ptr;
          VRAM_DATA   <= idle_data;
          LAST_WORD   <= idle_data;
        end
        if (SET_ADDR)     wr_ptr <= ADDR_IN;
        else if (idle_wr) wr_ptr <= wr_ptr + 1'b1;
      end

      if (word_to_pend) begin
        pend_vld  <= 1'b1;
        pend_data <= word;
      end else if (idle_wr && pend_vld) begin
        pend_vld <= 1'b0;
      end
      if (word_drop) OVERFLOW <= 1'b1;
    end
  end
endmodule
